serial_adder: RTL and testbench

- Parametrised bit-serial adder/subtractor built around a single full-adder cell and a carry flip-flop.
- Adds or subtracts two WIDTH-bit operands, processing one bit per clock, LSB first.
- Start/ready/done handshake; registered sum, carry-out and signed-overflow flag.
- Area-lean arithmetic unit for datapaths where latency is cheaper than a WIDTH-bit ripple adder.

---
 rtl/serial_adder.sv | 154 +++++++++++++++
 tb/tb_serial_adder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder/subtractor built from one full-adder cell and a carry
// flip-flop. It processes WIDTH bits one per clock, LSB first.
//
// Handshake:
//   - ready is high in IDLE and DONE. While ready is high, start=1 is accepted
//     on the next rising edge and the operands are latched.
//   - busy is high while the serial operation runs.
//   - done pulses high for one cycle, in the same cycle that sum, cout and
//     overflow take their new values.
//   - The results hold until the next operation completes.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   start    request; sampled only while ready=1
//   sub      0 = a+b+cin, 1 = a-b (cin ignored)
//   a, b     WIDTH-bit operands, latched on an accepted start
//   cin      carry-in for add, latched on an accepted start
//   ready    block can accept start
//   busy     serial operation in progress
//   done     one-cycle completion pulse
//   sum      WIDTH-bit result
//   cout     final carry-out (for subtract, 1 = no borrow)
//   overflow two's-complement overflow of the last result
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             bit_s;
    logic             bit_c;
    logic             last_bit;

    // The single full-adder cell, operating on the current LSBs.
    always_comb begin
        bit_s    = sa_q[0] ^ sb_q[0] ^ c_q;
        bit_c    = (sa_q[0] & sb_q[0]) | (sb_q[0] & c_q) | (c_q & sa_q[0]);
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            r_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            r_q     <= r_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        r_d     = r_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            // DONE accepts a new start exactly like IDLE. This allows
            // back-to-back operation at one result per WIDTH+1 cycles.
            S_IDLE, S_DONE: begin
                if (start) begin
                    sa_d    = a;
                    // Subtract is a + ~b + 1: invert B and force the carry-in.
                    sb_d    = sub ? ~b : b;
                    c_d     = sub | cin;
                    cnt_d   = '0;
                    state_d = S_ADD;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_ADD: begin
                sa_d = sa_q >> 1;
                sb_d = sb_q >> 1;
                c_d  = bit_c;
                r_d  = {bit_s, r_q[WIDTH-1:1]};
                if (last_bit) begin
                    sum_d   = {bit_s, r_q[WIDTH-1:1]};
                    cout_d  = bit_c;
                    // c_q here is the carry into the MSB.
                    ovf_d   = c_q ^ bit_c;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign ready    = (state_q != S_ADD);
    assign busy     = (state_q == S_ADD);
    assign done     = (state_q == S_DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Directed testbench for serial_adder with WIDTH=8.
//
// Expected results come from a word-level arithmetic model. They are pushed
// onto a queue when an operation is issued and popped when done is seen.
// DUT outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Word-level reference model.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic s);
        logic [W-1:0] yy;
        logic [W:0]   full;
        exp_t         e;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + (s ? (W+1)'(1) : (W+1)'(ci));
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.v  = (x[W-1] == yy[W-1]) && (e.s[W-1] != x[W-1]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic s);
        a     = x;
        b     = y;
        cin   = ci;
        sub   = s;
        start = 1'b1;
        sb_q.push_back(model(x, y, ci, s));
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'(1));
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_sum"},  64'(sum),      64'(e.s));
            chk({tag, "_cout"}, 64'(cout),     64'(e.c));
            chk({tag, "_ovf"},  64'(overflow), 64'(e.v));
            $display("op %s: sum=%02h cout=%0d ovf=%0d (exp %02h %0d %0d)",
                     tag, sum, cout, overflow, e.s, e.c, e.v);
        end
    endtask

    // Single operation from idle, with latency and handshake checks.
    // Must be called at a falling edge.
    task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic s);
        int cycles;
        logic [W-1:0] held;
        issue(x, y, ci, s);
        held = sum;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        chk({tag, "_busy"}, 64'(busy), 64'(1));
        chk({tag, "_ready_low"}, 64'(ready), 64'(0));
        while (!done && cycles < 20) begin
            if (cycles == 8) chk({tag, "_sum_held"}, 64'(sum), 64'(held));
            @(negedge clk);
            cycles++;
        end
        chk({tag, "_latency"}, 64'(cycles), 64'(9));
        chk({tag, "_done_ready"}, 64'(ready), 64'(1));
        check_result(tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'(0));
    endtask

    initial begin
        int ndone;
        int cyc;
        int last;
        int got;
        int issued;
        logic [W-1:0] ba [4];
        logic [W-1:0] bb [4];
        logic         bs [4];

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(ready), 64'(1));
        chk("rst_busy",  64'(busy),  64'(0));
        chk("rst_done",  64'(done),  64'(0));
        chk("rst_sum",   64'(sum),   64'(0));
        chk("rst_cout",  64'(cout),  64'(0));
        chk("rst_ovf",   64'(overflow), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Directed add, subtract and carry-chain cases.
        do_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0);
        do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        do_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0);
        do_op("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b1);
        do_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1);

        // Start and operand changes during ADD must be ignored.
        issue(8'h33, 8'h44, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; sub = 1'b1; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) begin
                ndone++;
                check_result("busy_ignore");
            end
            @(negedge clk);
        end
        chk("busy_ignore_ndone", 64'(ndone), 64'(1));

        // Reset in the middle of an operation.
        issue(8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        void'(sb_q.pop_back());
        chk("midrst_sum",   64'(sum),      64'(0));
        chk("midrst_cout",  64'(cout),     64'(0));
        chk("midrst_ovf",   64'(overflow), 64'(0));
        chk("midrst_ready", 64'(ready),    64'(1));
        chk("midrst_busy",  64'(busy),     64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_no_done", 64'(ndone), 64'(0));
        do_op("post_rst_01_01", 8'h01, 8'h01, 1'b0, 1'b0);

        // Back-to-back operation with start held high.
        ba = '{8'h7F, 8'hC3, 8'h00, 8'h99};
        bb = '{8'h01, 8'h3D, 8'h01, 8'h66};
        bs = '{1'b0,  1'b1,  1'b1,  1'b0};
        issue(ba[0], bb[0], 1'b0, bs[0]);
        issued = 1;
        got    = 0;
        cyc    = 0;
        last   = 0;
        while (got < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            chk("b2b_ready_only_done", 64'(ready), 64'(done));
            if (done) begin
                check_result("b2b");
                chk("b2b_period", 64'(cyc - last), 64'(9));
                last = cyc;
                got++;
                if (issued < 4) begin
                    issue(ba[issued], bb[issued], 1'b1, bs[issued]);
                    issued++;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("b2b_count", 64'(got), 64'(4));
        chk("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
